spi_ram_master: RTL and testbench

SPI_RAM_MASTER -- requirements
Module: spi_ram_master

---
 rtl/spi_ram_pkg.sv | 27 ++
 rtl/spi_ram_master_if.sv | 26 ++
 rtl/spi_shift_reg.sv | 42 ++++
 rtl/spi_ram_master.sv | 159 +++++++++++++++
 tb/tb_spi_ram_master.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI RAM master and its slave: frame geometry,
// command encodings and the frame-sequencer state encoding.
package spi_ram_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TURN  = 3'd3,
    ST_RECV  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Only read-data frames have a turnaround and a receive phase.
  function automatic logic is_read_data(input logic [1:0] cmd);
    return cmd == CMD_RD_DATA;
  endfunction

endpackage

// File: rtl/spi_ram_master_if.sv
// Host request/response and SPI pin bundle for spi_ram_master; the master
// modport is the controller's view, the slave modport the opposite side.
interface spi_ram_master_if;

  logic                              start;
  logic [1:0]                        cmd;
  logic [spi_ram_pkg::DATA_W-1:0]    wdata;
  logic                              busy;
  logic                              done;
  logic [spi_ram_pkg::DATA_W-1:0]    rdata;
  logic                              rdata_valid;
  logic                              ss_n;
  logic                              mosi;
  logic                              miso;

  modport master (
    input  start, cmd, wdata, miso,
    output busy, done, rdata, rdata_valid, ss_n, mosi
  );

  modport slave (
    output start, cmd, wdata, miso,
    input  busy, done, rdata, rdata_valid, ss_n, mosi
  );

endinterface

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register, MSB first: ser_out is the current MSB and
// ser_in enters at the LSB on every enabled shift. Load wins over shift.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         ser_in,
  output logic         ser_out,
  output logic [W-1:0] par_out
);

  logic [W-1:0] sr_q, sr_d;

  // NOTE: next-state logic assigns a default first so no path leaves sr_d
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_val;
    end else if (shift_en) begin
      sr_d = {sr_q[W-2:0], ser_in};
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_out = sr_q[W-1];
  assign par_out = sr_q;

endmodule

// File: rtl/spi_ram_master.sv
// SPI master for a serial RAM: sends one {cmd, wdata} frame per request and,
// for read-data frames, waits RD_WAIT cycles and then captures one byte.
module spi_ram_master
  import spi_ram_pkg::*;
#(
  parameter int unsigned RD_WAIT = 2
) (
  input logic              clk,
  input logic              rst,
  spi_ram_master_if.master bus
);

  localparam logic [3:0] SHIFT_LAST = 4'(FRAME_W - 1);
  localparam logic [3:0] RECV_LAST  = 4'(DATA_W - 1);
  localparam logic [3:0] TURN_LAST  = 4'((RD_WAIT == 0) ? 0 : RD_WAIT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_q, rd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic               tx_load, tx_shift, tx_ser;
  logic [FRAME_W-1:0] tx_par;
  logic               rx_load, rx_shift, rx_ser;
  logic [DATA_W-1:0]  rx_par;

  spi_shift_reg #(.W(FRAME_W)) u_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (tx_load),
    .load_val ({bus.cmd, bus.wdata}),
    .shift_en (tx_shift),
    .ser_in   (1'b0),
    .ser_out  (tx_ser),
    .par_out  (tx_par)
  );

  spi_shift_reg #(.W(DATA_W)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .load     (rx_load),
    .load_val ('0),
    .shift_en (rx_shift),
    .ser_in   (bus.miso),
    .ser_out  (rx_ser),
    .par_out  (rx_par)
  );

  // The TX parallel view and RX serial output have no consumer here.
  logic unused_bits;
  assign unused_bits = ^{tx_par, rx_ser, rx_par[DATA_W-1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    rdata_d  = rdata_q;
    tx_load  = 1'b0;
    tx_shift = 1'b0;
    rx_load  = 1'b0;
    rx_shift = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          tx_load = 1'b1;
          rx_load = 1'b1;
          rd_d    = is_read_data(bus.cmd);
          cnt_d   = '0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        tx_shift = 1'b1;
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = '0;
          if (!rd_q)             state_d = ST_DONE;
          else if (RD_WAIT == 0) state_d = ST_RECV;
          else                   state_d = ST_TURN;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = ST_RECV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RECV: begin
        rx_shift = 1'b1;
        if (cnt_q == RECV_LAST) begin
          // The last bit lands in the shifter on this same edge, so take it
          // straight from the pin to publish the whole byte at once.
          rdata_d = {rx_par[DATA_W-2:0], bus.miso};
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: every register here, including the rdata holding register, is
  // reset because its value is visible at the ports right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    bus.ss_n        = 1'b1;
    bus.mosi        = 1'b0;
    bus.busy        = (state_q != ST_IDLE);
    bus.done        = 1'b0;
    bus.rdata_valid = 1'b0;
    case (state_q)
      ST_CMD, ST_SHIFT: begin
        bus.ss_n = 1'b0;
        bus.mosi = tx_ser;
      end
      ST_TURN, ST_RECV: begin
        bus.ss_n = 1'b0;
      end
      ST_DONE: begin
        bus.done        = 1'b1;
        bus.rdata_valid = rd_q;
      end
      default: ;
    endcase
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Self-checking bench for spi_ram_master: a behavioural SPI RAM slave plus
// frame-level expectations (bit order, select length, latency, read-back).
module tb_spi_ram_master;
  import spi_ram_pkg::*;

  localparam int unsigned RD_WAIT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_ram_master_if bus();

  spi_ram_master #(.RD_WAIT(RD_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural slave: an address pointer and a 256-byte memory.
  logic [7:0] ram [256];
  logic [7:0] slv_addr;
  logic [7:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame timing from the protocol: CMD + 10 frame bits + DONE, plus the
  // turnaround and 8 receive bits for read-data.
  function automatic int frame_len(input logic [1:0] c);
    return (c == CMD_RD_DATA) ? 20 + int'(RD_WAIT) : 12;
  endfunction

  function automatic int sel_len(input logic [1:0] c);
    return (c == CMD_RD_DATA) ? 19 + int'(RD_WAIT) : 11;
  endfunction

  task automatic slave_apply(input logic [1:0] c, input logic [7:0] d);
    case (c)
      CMD_WR_ADDR, CMD_RD_ADDR: slv_addr = d;
      CMD_WR_DATA:              ram[slv_addr] = d;
      default:                  ;
    endcase
  endtask

  task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input bit glitch);
    int         len   = frame_len(c);
    int         recv0 = 12 + int'(RD_WAIT);
    bit         rd    = (c == CMD_RD_DATA);
    logic [7:0] resp  = ram[slv_addr];
    logic [10:0] bits = '0;
    int         nbits = 0;
    logic       tail  = 1'b0;
    int         low   = 0;
    int         bsy   = 0;
    int         dn    = 0;
    int         dn_at = -1;
    logic       rv    = 1'b0;
    logic [7:0] rdv   = '0;

    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd   = c;
    bus.wdata = d;
    @(negedge clk);
    bus.start = 1'b0;
    bus.cmd   = 2'($urandom);
    bus.wdata = 8'($urandom);
    for (int n = 1; n <= len + 1; n++) begin
      if (!bus.ss_n) begin
        low++;
        if (nbits < 11) begin
          bits = {bits[9:0], bus.mosi};
          nbits++;
        end else begin
          tail |= bus.mosi;
        end
      end
      if (bus.busy) bsy++;
      if (bus.done) begin
        dn++;
        dn_at = n;
        rv    = bus.rdata_valid;
        rdv   = bus.rdata;
      end
      if (rd && n >= recv0 && n < recv0 + 8) bus.miso = resp[7 - (n - recv0)];
      else                                    bus.miso = 1'($urandom);
      if (glitch && n == 5) begin
        bus.start = 1'b1;
        bus.cmd   = ~c;
        bus.wdata = ~d;
      end
      if (glitch && n == 6) bus.start = 1'b0;
      @(negedge clk);
    end

    if (rd) last_rdata = resp;
    check("ss_low_cycles", low, sel_len(c));
    check("mosi_bits", bits, {c[1], c, d});
    check("mosi_after_frame", tail, 1'b0);
    check("busy_cycles", bsy, len);
    check("done_cycle", dn_at, len);
    check("done_count", dn, 1);
    check("rdata_valid", rv, rd);
    check("rdata", rdv, last_rdata);
    slave_apply(bits[9:8], bits[7:0]);
  endtask

  // Read-data frame cut by reset while receiving bit index 4.
  task automatic run_abort_read();
    int         recv0 = 12 + int'(RD_WAIT);
    logic [7:0] resp  = ram[slv_addr];
    int         dn    = 0;
    int         low   = 0;

    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd   = CMD_RD_DATA;
    bus.wdata = 8'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 1; n < recv0 + 4; n++) begin
      if (bus.done) dn++;
      if (n >= recv0) bus.miso = resp[7 - (n - recv0)];
      else            bus.miso = 1'($urandom);
      @(negedge clk);
    end
    bus.miso = resp[3];
    rst      = 1'b1;
    @(negedge clk);
    check("abort_ss_n", bus.ss_n, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_rdata", bus.rdata, 8'h00);
    check("abort_mosi", bus.mosi, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_rvalid", bus.rdata_valid, 1'b0);
    rst = 1'b0;
    for (int n = 0; n < 24; n++) begin
      if (bus.done) dn++;
      if (!bus.ss_n) low++;
      @(negedge clk);
    end
    check("abort_no_done", dn, 0);
    check("abort_stays_idle", low, 0);
    last_rdata = 8'h00;
  endtask

  // start held high with write-data: one frame every 13 cycles.
  task automatic run_stream(input logic [7:0] d);
    int prev_done = -1;
    int gaps_bad  = 0;
    int ndone     = 0;
    int hi_run    = 0;
    int runs_bad  = 0;
    int nruns     = 0;
    bit seen_low  = 1'b0;
    bit idle      = 1'b0;

    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd   = CMD_WR_DATA;
    bus.wdata = d;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (bus.done) begin
        if (prev_done >= 0 && n - prev_done != 13) gaps_bad++;
        prev_done = n;
        ndone++;
      end
      if (bus.ss_n) begin
        hi_run++;
      end else begin
        if (seen_low && hi_run > 0) begin
          nruns++;
          if (hi_run != 2) runs_bad++;
        end
        seen_low = 1'b1;
        hi_run   = 0;
      end
    end
    bus.start = 1'b0;
    for (int n = 0; n < 30 && !idle; n++) begin
      @(negedge clk);
      idle = !bus.busy;
    end
    check("stream_drained", idle, 1'b1);
    check("stream_period_errors", gaps_bad, 0);
    check("stream_done_count", ndone, 5);
    check("stream_gap_errors", runs_bad, 0);
    check("stream_gap_count", nruns, 5);
    ram[slv_addr] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    slv_addr   = 8'h00;
    last_rdata = 8'h00;
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.cmd    = CMD_RD_DATA;
    bus.wdata  = 8'hFF;
    bus.miso   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss_n", bus.ss_n, 1'b1);
    check("rst_mosi", bus.mosi, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_rvalid", bus.rdata_valid, 1'b0);
    check("rst_rdata", bus.rdata, 8'h00);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("start_in_rst_ignored", bus.busy, 1'b0);

    // Write-address 5A, then store A6 and read it back.
    run_frame(CMD_WR_ADDR, 8'h5A, 1'b0);
    run_frame(CMD_WR_DATA, 8'hA6, 1'b0);
    run_frame(CMD_RD_ADDR, 8'h5A, 1'b0);
    run_frame(CMD_RD_DATA, 8'h00, 1'b0);
    check("read_a6", bus.rdata, 8'hA6);

    // RAM loop at address 10.
    run_frame(CMD_WR_ADDR, 8'h10, 1'b0);
    run_frame(CMD_WR_DATA, 8'h3C, 1'b0);
    run_frame(CMD_RD_ADDR, 8'h10, 1'b0);
    run_frame(CMD_RD_DATA, 8'($urandom), 1'b0);
    check("ram_loop_rdata", bus.rdata, 8'h3C);

    // start pulsed mid-shift must not disturb the frame in flight.
    run_frame(CMD_WR_DATA, 8'hC3, 1'b1);
    run_frame(CMD_RD_DATA, 8'h55, 1'b1);

    run_abort_read();
    run_frame(CMD_WR_ADDR, 8'h77, 1'b0);

    run_stream(8'h81);

    repeat (40) run_frame(2'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
